// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: condition codes and stage payload.
package bru_pkg;

    // Widest supported PC; payload carries the PC zero-extended to this width.
    localparam int unsigned BRU_PC_W = 64;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef struct packed {
        logic                taken;
        logic                mispredict;
        logic                illegal;
        logic [BRU_PC_W-1:0] redirect_pc;
    } bru_payload_t;

endpackage

// File: rtl/bru_pipe_stage.sv
// Single valid/ready register slice with flush for the branch resolve pipeline.
module bru_pipe_stage
    import bru_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         up_valid,
    output logic         up_ready_c,
    input  bru_payload_t up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output bru_payload_t dn_data
);

    // Slice advances when empty or when downstream takes the current entry.
    assign up_ready_c = !dn_valid || dn_ready;

    // Valid/payload register; flush drops the entry and any same-cycle accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (flush_i) begin
            dn_valid <= 1'b0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition evaluation, mispredict detection,
// redirect PC, a STAGES-deep valid/ready pipeline and saturating statistics.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  opa_i,
    input  logic [XLEN-1:0]  opb_i,
    input  logic [2:0]       funct3_i,
    input  logic             is_jump_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             illegal_o,
    input  logic             stat_clr_i,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispred_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            cond;
    logic            cond_illegal;
    logic            taken;
    logic [XLEN-1:0] redirect_pc;
    bru_payload_t    eval_pl;
    bru_payload_t    out_pl;
    logic            out_hs;

    logic            stg_valid [STAGES+1];
    logic            stg_ready [STAGES+1];
    bru_payload_t    stg_data  [STAGES+1];

    // Stage-0 condition evaluation, mispredict check and next-PC selection.
    always_comb begin
        cond         = 1'b0;
        cond_illegal = 1'b0;
        case (funct3_i)
            BR_EQ:   cond = (opa_i == opb_i);
            BR_NE:   cond = (opa_i != opb_i);
            BR_LT:   cond = ($signed(opa_i) <  $signed(opb_i));
            BR_GE:   cond = ($signed(opa_i) >= $signed(opb_i));
            BR_LTU:  cond = (opa_i <  opb_i);
            BR_GEU:  cond = (opa_i >= opb_i);
            default: cond_illegal = 1'b1;
        endcase

        taken       = is_jump_i || cond;
        redirect_pc = taken ? target_i : (pc_i + XLEN'(4));

        eval_pl             = '0;
        eval_pl.taken       = taken;
        eval_pl.illegal     = cond_illegal && !is_jump_i;
        eval_pl.mispredict  = (taken != pred_taken_i) ||
                              (taken && (pred_target_i != target_i));
        eval_pl.redirect_pc = BRU_PC_W'(redirect_pc);
    end

    // Pipeline chain: index 0 is the request port, index STAGES the result port.
    assign stg_valid[0]      = valid_i;
    assign stg_data[0]       = eval_pl;
    assign ready_o           = stg_ready[0];
    assign stg_ready[STAGES] = ready_i;

    for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
        bru_pipe_stage u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .up_valid   (stg_valid[i]),
            .up_ready_c (stg_ready[i]),
            .up_data    (stg_data[i]),
            .dn_valid   (stg_valid[i+1]),
            .dn_ready   (stg_ready[i+1]),
            .dn_data    (stg_data[i+1])
        );
    end

    assign out_pl        = stg_data[STAGES];
    assign valid_o       = stg_valid[STAGES];
    assign taken_o       = out_pl.taken;
    assign mispredict_o  = out_pl.mispredict;
    assign illegal_o     = out_pl.illegal;
    assign redirect_pc_o = out_pl.redirect_pc[XLEN-1:0];
    assign out_hs        = valid_o && ready_i;

    // Upper payload PC bits are always zero when XLEN is narrower than the payload.
    if (XLEN < BRU_PC_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^out_pl.redirect_pc[BRU_PC_W-1:XLEN];
    end

    // Saturating statistics on output handshakes; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (stat_clr_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (out_hs) begin
            if (stat_branches_o != CNT_MAX) begin
                stat_branches_o <= stat_branches_o + CNT_W'(1);
            end
            if (out_pl.mispredict && (stat_mispred_o != CNT_MAX)) begin
                stat_mispred_o <= stat_mispred_o + CNT_W'(1);
            end
        end
    end

endmodule
